// File: rtl/el2_ahb_master_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter and multiplexer for the EL2 core.
// M0 is the instruction-fetch port and M1 the LSU port. The core ignores
// HGRANT, so a master that does not own the bus is stalled through its HREADY.
// Optional build macro: EL2_ARB_ROUND_ROBIN_EN. It selects alternating
// priority and lets the owner yield after every accepted NONSEQ. Without it,
// M1 has fixed priority over M0.
module el2_ahb_master_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 64,
    parameter int PARK_MASTER = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic [2:0]    M0_HSIZE,
    input  logic [2:0]    M0_HBURST,
    input  logic [3:0]    M0_HPROT,
    input  logic          M0_HWRITE,
    input  logic          M0_HMASTLOCK,
    input  logic [DW-1:0] M0_HWDATA,
    input  logic          M0_HBUSREQ,
    output logic          M0_HGRANT,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic [2:0]    M1_HSIZE,
    input  logic [2:0]    M1_HBURST,
    input  logic [3:0]    M1_HPROT,
    input  logic          M1_HWRITE,
    input  logic          M1_HMASTLOCK,
    input  logic [DW-1:0] M1_HWDATA,
    input  logic          M1_HBUSREQ,
    output logic          M1_HGRANT,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic [2:0]    S_HSIZE,
    output logic [2:0]    S_HBURST,
    output logic [3:0]    S_HPROT,
    output logic          S_HWRITE,
    output logic          S_HMASTLOCK,
    output logic [DW-1:0] S_HWDATA,
    input  logic [DW-1:0] S_HRDATA,
    input  logic          S_HREADY
);

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

    localparam master_e PARK = (PARK_MASTER == 1) ? MST_M1 : MST_M0;

    master_e owner;      // address-phase owner
    master_e owner_nxt;
    master_e dp_owner;   // data-phase owner
    logic    dp_valid;   // a transfer is in its data phase
    logic    owner_idle; // owner presents IDLE/BUSY and holds no lock

`ifdef EL2_ARB_ROUND_ROBIN_EN
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    master_e last;       // master whose NONSEQ was accepted most recently
    logic    other_req;  // the non-owner is requesting
`endif

    // Address-phase mux: the slave sees the owner's control signals
    always_comb begin
        if (owner == MST_M1) begin
            S_HADDR     = M1_HADDR;
            S_HTRANS    = M1_HTRANS;
            S_HSIZE     = M1_HSIZE;
            S_HBURST    = M1_HBURST;
            S_HPROT     = M1_HPROT;
            S_HWRITE    = M1_HWRITE;
            S_HMASTLOCK = M1_HMASTLOCK;
        end else begin
            S_HADDR     = M0_HADDR;
            S_HTRANS    = M0_HTRANS;
            S_HSIZE     = M0_HSIZE;
            S_HBURST    = M0_HBURST;
            S_HPROT     = M0_HPROT;
            S_HWRITE    = M0_HWRITE;
            S_HMASTLOCK = M0_HMASTLOCK;
        end
    end

    // Write data follows the data-phase owner; read data goes to both masters
    assign S_HWDATA  = (dp_owner == MST_M1) ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

    assign M0_HGRANT = (owner == MST_M0);
    assign M1_HGRANT = (owner == MST_M1);

    // The grant may only move when the owner is between transfers and unlocked
    assign owner_idle = !S_HTRANS[1] && !S_HMASTLOCK;

`ifdef EL2_ARB_ROUND_ROBIN_EN
    assign other_req = (owner == MST_M0) ? M1_HBUSREQ : M0_HBUSREQ;
`endif

    // Next owner: winner among requesters at a switch point, else unchanged
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first,
        // so no path can leave it unassigned and infer a latch.
        owner_nxt = owner;
        if (owner_idle) begin
`ifdef EL2_ARB_ROUND_ROBIN_EN
            if (M0_HBUSREQ && M1_HBUSREQ) begin
                owner_nxt = (last == MST_M0) ? MST_M1 : MST_M0;
            end else if (M1_HBUSREQ) begin
                owner_nxt = MST_M1;
            end else if (M0_HBUSREQ) begin
                owner_nxt = MST_M0;
            end
`else
            if (M1_HBUSREQ) begin
                owner_nxt = MST_M1;
            end else if (M0_HBUSREQ) begin
                owner_nxt = MST_M0;
            end
`endif
        end
`ifdef EL2_ARB_ROUND_ROBIN_EN
        else if ((S_HTRANS == HTRANS_NONSEQ) && !S_HMASTLOCK && other_req) begin
            // Yield right after the owner's NONSEQ is accepted
            owner_nxt = (owner == MST_M0) ? MST_M1 : MST_M0;
        end
`endif
    end

    // Per-master ready: owners see the slave, waiting requesters are stalled
    always_comb begin
        M0_HREADY = !M0_HBUSREQ;
        M1_HREADY = !M1_HBUSREQ;
        if ((owner == MST_M0) || (dp_valid && (dp_owner == MST_M0))) begin
            M0_HREADY = S_HREADY;
        end
        if ((owner == MST_M1) || (dp_valid && (dp_owner == MST_M1))) begin
            M1_HREADY = S_HREADY;
        end
    end

    // Arbitration state advances only when the slave completes a cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner    <= PARK;
            dp_owner <= PARK;
            dp_valid <= 1'b0;
        end else if (S_HREADY) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            owner    <= owner_nxt;
            dp_owner <= owner;
            dp_valid <= S_HTRANS[1];
        end
    end

`ifdef EL2_ARB_ROUND_ROBIN_EN
    // Remember who was served last to alternate on contention
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last <= PARK;
        end else if (S_HREADY && (S_HTRANS == HTRANS_NONSEQ)) begin
            last <= owner;
        end
    end
`endif

endmodule

// File: tb/tb_el2_ahb_master_arbiter.sv
// Self-checking bench for el2_ahb_master_arbiter: directed scenarios first,
// then randomized traffic from two AHB master models and a slave model.
module tb_el2_ahb_master_arbiter;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] m_haddr   [2];
    logic [1:0]  m_htrans  [2];
    logic [2:0]  m_hsize   [2];
    logic [2:0]  m_hburst  [2];
    logic [3:0]  m_hprot   [2];
    logic        m_hwrite  [2];
    logic        m_hlock   [2];
    logic [63:0] m_hwdata  [2];
    logic        m_busreq  [2];
    logic [63:0] m_hrdata  [2];
    logic        M0_HGRANT, M1_HGRANT, M0_HREADY, M1_HREADY;
    logic [31:0] S_HADDR;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE, S_HBURST;
    logic [3:0]  S_HPROT;
    logic        S_HWRITE, S_HMASTLOCK;
    logic [63:0] S_HWDATA;
    logic [63:0] S_HRDATA;
    logic        S_HREADY;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    el2_ahb_master_arbiter dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(m_haddr[0]), .M0_HTRANS(m_htrans[0]), .M0_HSIZE(m_hsize[0]),
        .M0_HBURST(m_hburst[0]), .M0_HPROT(m_hprot[0]), .M0_HWRITE(m_hwrite[0]),
        .M0_HMASTLOCK(m_hlock[0]), .M0_HWDATA(m_hwdata[0]), .M0_HBUSREQ(m_busreq[0]),
        .M0_HGRANT(M0_HGRANT), .M0_HREADY(M0_HREADY), .M0_HRDATA(m_hrdata[0]),
        .M1_HADDR(m_haddr[1]), .M1_HTRANS(m_htrans[1]), .M1_HSIZE(m_hsize[1]),
        .M1_HBURST(m_hburst[1]), .M1_HPROT(m_hprot[1]), .M1_HWRITE(m_hwrite[1]),
        .M1_HMASTLOCK(m_hlock[1]), .M1_HWDATA(m_hwdata[1]), .M1_HBUSREQ(m_busreq[1]),
        .M1_HGRANT(M1_HGRANT), .M1_HREADY(M1_HREADY), .M1_HRDATA(m_hrdata[1]),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE),
        .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HWRITE(S_HWRITE),
        .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
        .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Slave read data is a fixed function of the address in data phase
    function automatic logic [63:0] rd_fn(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic set_m(input int m, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic lock, input logic [63:0] wdata);
        m_htrans[m] = trans;
        m_busreq[m] = trans[1];
        m_haddr[m]  = addr;
        m_hwrite[m] = wr;
        m_hlock[m]  = lock;
        m_hwdata[m] = wdata;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    // Randomized master model state (address phase and data phase)
    logic        ap_v [2];
    logic [31:0] ap_a [2];
    logic        ap_w [2];
    logic [63:0] ap_d [2];
    logic [3:0]  ap_p [2];
    logic        dp_v [2];
    logic [31:0] dp_a [2];
    logic        dp_w [2];
    logic [63:0] dp_d [2];
    int          done [2];
    int          stall [2];
    int          max_stall;
    logic [31:0] s_dp_addr;

    task automatic new_ap(input int m);
        ap_v[m] = ($urandom_range(0, 1) == 1);
        ap_a[m] = {(m == 1), 3'b000, 25'($urandom), 3'b000};
        ap_w[m] = 1'($urandom_range(0, 1));
        ap_d[m] = {$urandom, $urandom};
        ap_p[m] = 4'($urandom);
    endtask

    task automatic drive_models();
        for (int m = 0; m < 2; m++) begin
            m_htrans[m] = ap_v[m] ? NONSEQ : IDLE;
            m_busreq[m] = ap_v[m];
            m_haddr[m]  = ap_a[m];
            m_hwrite[m] = ap_w[m];
            m_hprot[m]  = ap_p[m];
            m_hlock[m]  = 1'b0;
            m_hwdata[m] = dp_d[m];
        end
        S_HRDATA = rd_fn(s_dp_addr);
    endtask

    initial begin
        int low_cnt;
        logic hr [2];
        int n_acc;
        logic s_acc;
        logic [31:0] s_addr;

        HRESETn  = 1'b0;
        S_HREADY = 1'b1;
        S_HRDATA = '0;
        for (int m = 0; m < 2; m++) begin
            set_m(m, IDLE, 32'h0, 1'b0, 1'b0, 64'h0);
            m_hsize[m]  = 3'b011;
            m_hburst[m] = 3'b000;
            m_hprot[m]  = 4'b0011;
        end
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_m0_grant", 64'(M0_HGRANT), 64'(1));
        check("rst_m1_grant", 64'(M1_HGRANT), 64'(0));
        check("rst_s_htrans", 64'(S_HTRANS), 64'(0));
        check("rst_m0_ready", 64'(M0_HREADY), 64'(1));
        check("rst_m1_ready", 64'(M1_HREADY), 64'(1));
        next_cycle();
        HRESETn = 1'b1;

        // M0 single read
        next_cycle();
        set_m(0, NONSEQ, 32'h0000_1000, 1'b0, 1'b0, 64'h0);
        @(negedge HCLK);
        check("m0rd_addr", 64'(S_HADDR), 64'(32'h1000));
        check("m0rd_trans", 64'(S_HTRANS), 64'(NONSEQ));
        check("m0rd_ready_a", 64'(M0_HREADY), 64'(1));
        next_cycle();
        set_m(0, IDLE, 32'h0000_1000, 1'b0, 1'b0, 64'h0);
        S_HRDATA = 64'hDEAD_BEEF_0000_0001;
        @(negedge HCLK);
        check("m0rd_data", m_hrdata[0], 64'hDEAD_BEEF_0000_0001);
        check("m0rd_ready_d", 64'(M0_HREADY), 64'(1));

        // M1 write: one IDLE cycle, then grant, then data
        next_cycle();
        set_m(1, NONSEQ, 32'h2000_0000, 1'b1, 1'b0, 64'h0);
        @(negedge HCLK);
        check("m1wr_idle_cycle", 64'(S_HTRANS), 64'(IDLE));
        check("m1wr_nogrant", 64'(M1_HGRANT), 64'(0));
        check("m1wr_stall", 64'(M1_HREADY), 64'(0));
        next_cycle();
        @(negedge HCLK);
        check("m1wr_grant", 64'(M1_HGRANT), 64'(1));
        check("m1wr_addr", 64'(S_HADDR), 64'(32'h2000_0000));
        check("m1wr_write", 64'(S_HWRITE), 64'(1));
        check("m1wr_ready_a", 64'(M1_HREADY), 64'(1));
        next_cycle();
        set_m(1, IDLE, 32'h2000_0000, 1'b0, 1'b0, 64'h55);
        @(negedge HCLK);
        check("m1wr_wdata", S_HWDATA, 64'h55);
        check("m1wr_ready_d", 64'(M1_HREADY), 64'(1));

        // Simultaneous requests: M1 first, M0 two cycles later
        next_cycle();
        set_m(0, NONSEQ, 32'h0000_3000, 1'b0, 1'b0, 64'h0);
        set_m(1, NONSEQ, 32'h0000_4000, 1'b0, 1'b0, 64'h0);
        @(negedge HCLK);
        check("both_addr_m1", 64'(S_HADDR), 64'(32'h4000));
        check("both_m1_ready", 64'(M1_HREADY), 64'(1));
        check("both_m0_stall0", 64'(M0_HREADY), 64'(0));
        next_cycle();
        set_m(1, IDLE, 32'h0000_4000, 1'b0, 1'b0, 64'h0);
        S_HRDATA = 64'h0123_4567_89AB_CDEF;
        @(negedge HCLK);
        check("both_m0_stall1", 64'(M0_HREADY), 64'(0));
        check("both_switch_idle", 64'(S_HTRANS), 64'(IDLE));
        check("both_m1_rdata", m_hrdata[1], 64'h0123_4567_89AB_CDEF);
        next_cycle();
        @(negedge HCLK);
        check("both_m0_grant", 64'(M0_HGRANT), 64'(1));
        check("both_m0_addr", 64'(S_HADDR), 64'(32'h3000));
        check("both_m0_ready", 64'(M0_HREADY), 64'(1));
        next_cycle();
        set_m(0, IDLE, 32'h0000_3000, 1'b0, 1'b0, 64'h0);
        S_HRDATA = 64'hFEED_0000_CAFE_0003;
        @(negedge HCLK);
        check("both_m0_rdata", m_hrdata[0], 64'hFEED_0000_CAFE_0003);

        // Slave wait states during an M1 data phase
        next_cycle();
        set_m(1, NONSEQ, 32'h0000_5000, 1'b0, 1'b0, 64'h0);
        @(negedge HCLK);
        check("ws_m1_stall", 64'(M1_HREADY), 64'(0));
        next_cycle();
        @(negedge HCLK);
        check("ws_m1_addr", 64'(S_HADDR), 64'(32'h5000));
        check("ws_m1_grant", 64'(M1_HGRANT), 64'(1));
        next_cycle();
        set_m(1, IDLE, 32'h0000_5000, 1'b0, 1'b0, 64'h0);
        set_m(0, NONSEQ, 32'h0000_6000, 1'b0, 1'b0, 64'h0);
        S_HREADY = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            @(negedge HCLK);
            check("ws_grant_frozen", 64'(M1_HGRANT), 64'(1));
            check("ws_addr_frozen", 64'(S_HADDR), 64'(32'h5000));
            check("ws_m0_stall", 64'(M0_HREADY), 64'(0));
            if (!M1_HREADY) low_cnt++;
        end
        next_cycle();
        S_HREADY = 1'b1;
        S_HRDATA = 64'h5555_AAAA_5555_0005;
        @(negedge HCLK);
        if (!M1_HREADY) low_cnt++;
        check("ws_low_cycles", 64'(low_cnt), 64'(3));
        check("ws_m1_rdata", m_hrdata[1], 64'h5555_AAAA_5555_0005);
        next_cycle();
        @(negedge HCLK);
        check("ws_m0_grant", 64'(M0_HGRANT), 64'(1));
        check("ws_m0_addr", 64'(S_HADDR), 64'(32'h6000));
        next_cycle();
        set_m(0, IDLE, 32'h0000_6000, 1'b0, 1'b0, 64'h0);

        // Locked M0 sequence holds off M1
        next_cycle();
        set_m(0, NONSEQ, 32'h0000_7000, 1'b1, 1'b1, 64'h0);
        set_m(1, NONSEQ, 32'h0000_8000, 1'b0, 1'b0, 64'h0);
        @(negedge HCLK);
        check("lk_grant0", 64'(M0_HGRANT), 64'(1));
        check("lk_m1_stall0", 64'(M1_HREADY), 64'(0));
        check("lk_lock", 64'(S_HMASTLOCK), 64'(1));
        next_cycle();
        set_m(0, IDLE, 32'h0000_7000, 1'b1, 1'b1, 64'hAA);
        @(negedge HCLK);
        check("lk_grant1", 64'(M0_HGRANT), 64'(1));
        check("lk_m1_stall1", 64'(M1_HREADY), 64'(0));
        check("lk_wdata", S_HWDATA, 64'hAA);
        next_cycle();
        set_m(0, NONSEQ, 32'h0000_7004, 1'b1, 1'b1, 64'h0);
        @(negedge HCLK);
        check("lk_grant2", 64'(M0_HGRANT), 64'(1));
        check("lk_addr2", 64'(S_HADDR), 64'(32'h7004));
        check("lk_m1_stall2", 64'(M1_HREADY), 64'(0));
        next_cycle();
        set_m(0, IDLE, 32'h0000_7004, 1'b0, 1'b0, 64'hBB);
        @(negedge HCLK);
        check("lk_grant3", 64'(M0_HGRANT), 64'(1));
        check("lk_m1_stall3", 64'(M1_HREADY), 64'(0));
        next_cycle();
        @(negedge HCLK);
        check("lk_m1_grant", 64'(M1_HGRANT), 64'(1));
        check("lk_m1_addr", 64'(S_HADDR), 64'(32'h8000));
        check("lk_m1_ready", 64'(M1_HREADY), 64'(1));

        // Reset during an M1 data phase
        next_cycle();
        set_m(1, IDLE, 32'h0000_8000, 1'b0, 1'b0, 64'h0);
        HRESETn = 1'b0;
        #1;
        check("rst2_m0_grant", 64'(M0_HGRANT), 64'(1));
        check("rst2_m1_grant", 64'(M1_HGRANT), 64'(0));
        check("rst2_s_htrans", 64'(S_HTRANS), 64'(IDLE));
        check("rst2_m1_ready", 64'(M1_HREADY), 64'(1));
        next_cycle();
        HRESETn = 1'b1;

        // Randomized traffic from two master models
        for (int m = 0; m < 2; m++) begin
            ap_v[m] = 1'b0; ap_a[m] = '0; ap_w[m] = 1'b0; ap_d[m] = '0; ap_p[m] = '0;
            dp_v[m] = 1'b0; dp_a[m] = '0; dp_w[m] = 1'b0; dp_d[m] = '0;
            done[m] = 0; stall[m] = 0;
        end
        max_stall = 0;
        s_dp_addr = '0;
        drive_models();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge HCLK);
            hr[0] = M0_HREADY;
            hr[1] = M1_HREADY;
            check("rnd_grant_onehot", 64'(M0_HGRANT ^ M1_HGRANT), 64'(1));
            check("rnd_addr_mux", 64'({S_HADDR, S_HWRITE, S_HPROT}),
                  M1_HGRANT ? 64'({m_haddr[1], m_hwrite[1], m_hprot[1]})
                            : 64'({m_haddr[0], m_hwrite[0], m_hprot[0]}));
            n_acc = 0;
            s_acc = S_HREADY && (S_HTRANS == NONSEQ);
            s_addr = S_HADDR;
            for (int m = 0; m < 2; m++) begin
                if (hr[m] && dp_v[m]) begin
                    if (dp_w[m]) check("rnd_wdata", S_HWDATA, dp_d[m]);
                    else         check("rnd_rdata", m_hrdata[m], rd_fn(dp_a[m]));
                    done[m]++;
                end
                if (hr[m] && ap_v[m]) begin
                    check("rnd_accept", 64'({S_HTRANS, S_HADDR}), 64'({NONSEQ, ap_a[m]}));
                    if (s_acc && (ap_a[m] == s_addr)) n_acc++;
                end
                if (ap_v[m] && !hr[m]) stall[m]++;
                else stall[m] = 0;
                if (stall[m] > max_stall) max_stall = stall[m];
            end
            if (s_acc) check("rnd_slave_accept_owner", 64'(n_acc), 64'(1));
            next_cycle();
            if (s_acc) s_dp_addr = s_addr;
            for (int m = 0; m < 2; m++) begin
                if (hr[m]) begin
                    dp_v[m] = ap_v[m];
                    dp_a[m] = ap_a[m];
                    dp_w[m] = ap_w[m];
                    dp_d[m] = ap_d[m];
                    new_ap(m);
                end
            end
            S_HREADY = ($urandom_range(0, 4) != 0);
            drive_models();
        end
        check("rnd_m0_progress", 64'(done[0] >= 50), 64'(1));
        check("rnd_m1_progress", 64'(done[1] >= 50), 64'(1));
        check("rnd_stall_bound", 64'(max_stall < 300), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
